button_input_frontend: RTL and testbench

- Input-side counterpart of the display path: raw, bouncy, asynchronous push buttons in; clean single-cycle command strobes out.
- Outputs feed the time-set/alarm logic as upTime / nextDigit / setValue / resetTime strobes.
- Per-button functions: 2-flop synchroniser, debounce counter, press/release edge detect, long-press detect, auto-repeat for selected buttons.
- Sits between the board pins and the watch control logic.

---
 rtl/button_input_frontend.sv | 172 +++++++++++++++++
 tb/tb_button_input_frontend.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_input_frontend.sv
// Push-button front end: synchronise, debounce, then turn each button into press/release/long/repeat strobes.
// Optional BTN_CHORD_EN adds a buttons-0+1 chord strobe; without it chordPulse is tied low.
module button_input_frontend #(
    parameter int               NBTN              = 4,
    parameter int               DEBOUNCE_CYCLES   = 1000,
    parameter int               LONG_PRESS_CYCLES = 50000,
    parameter int               REPEAT_CYCLES     = 10000,
    parameter logic [NBTN-1:0]  REPEAT_MASK       = NBTN'(1),
    parameter int               CNT_W             = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NBTN-1:0] btnIn,
    output logic [NBTN-1:0] btnState,
    output logic [NBTN-1:0] pressPulse,
    output logic [NBTN-1:0] releasePulse,
    output logic [NBTN-1:0] longPress,
    output logic            chordPulse
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, HELD, REPEAT, LONG} holdStateT;

    logic [NBTN-1:0] syncMeta;
    logic [NBTN-1:0] syncd;
    logic [NBTN-1:0] stable;
    logic [CNT_W-1:0] dbCnt [NBTN];
    logic [CNT_W-1:0] holdCnt [NBTN];
    holdStateT       state [NBTN];

    logic [NBTN-1:0] pressReq;
    logic [NBTN-1:0] releaseReq;
    logic [NBTN-1:0] longReq;
    logic [NBTN-1:0] repeatReq;
    logic [NBTN-1:0] pressSup;
    logic [NBTN-1:0] strobeSup;

`ifdef BTN_CHORD_EN
    logic chordActive;
    logic chordHit;
`endif

    assign btnState = stable;

    // btnIn is only ever seen through the two sync flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            syncMeta <= '0;
            syncd    <= '0;
            stable   <= '0;
            for (int i = 0; i < NBTN; i++) dbCnt[i] <= '0;
        end else begin
            syncMeta <= btnIn;
            syncd    <= syncMeta;
            for (int i = 0; i < NBTN; i++) begin
                if (syncd[i] == stable[i]) begin
                    dbCnt[i] <= '0;
                end else if (dbCnt[i] == DB_LAST) begin
                    stable[i] <= syncd[i];
                    dbCnt[i]  <= '0;
                end else if (dbCnt[i] != CNT_MAX) begin
                    dbCnt[i] <= dbCnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Strobe requests; release wins because long/repeat also require the button to be still down.
    always_comb begin
        pressReq   = '0;
        releaseReq = '0;
        longReq    = '0;
        repeatReq  = '0;
        pressSup   = '0;
        strobeSup  = '0;
        for (int i = 0; i < NBTN; i++) begin
            pressReq[i]   = (state[i] == IDLE) && stable[i];
            releaseReq[i] = (state[i] != IDLE) && !stable[i];
            longReq[i]    = (state[i] == HELD) && stable[i] && (holdCnt[i] == LP_LAST);
            repeatReq[i]  = (state[i] == REPEAT) && stable[i] && (holdCnt[i] == RP_LAST);
        end
`ifdef BTN_CHORD_EN
        chordHit = !chordActive &&
                   ((pressReq[0] && (pressReq[1] || (state[1] == HELD && stable[1]))) ||
                    (pressReq[1] && state[0] == HELD && stable[0]));
        // The later press becomes the chord; on a tie button 1 is treated as the later one.
        if (chordHit) begin
            if (pressReq[1]) pressSup[1] = 1'b1;
            else             pressSup[0] = 1'b1;
        end
        if (chordHit || chordActive) strobeSup[1:0] = 2'b11;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pressPulse   <= '0;
            releasePulse <= '0;
            longPress    <= '0;
            for (int i = 0; i < NBTN; i++) begin
                state[i]   <= IDLE;
                holdCnt[i] <= '0;
            end
        end else begin
            pressPulse   <= (pressReq & ~pressSup) | (repeatReq & ~strobeSup);
            releasePulse <= releaseReq;
            longPress    <= longReq & ~strobeSup;
            for (int i = 0; i < NBTN; i++) begin
                case (state[i])
                    IDLE: begin
                        if (stable[i]) begin
                            state[i]   <= HELD;
                            holdCnt[i] <= '0;
                        end
                    end
                    HELD: begin
                        if (!stable[i]) begin
                            state[i]   <= IDLE;
                            holdCnt[i] <= '0;
                        end else if (holdCnt[i] == LP_LAST) begin
                            holdCnt[i] <= '0;
                            state[i]   <= REPEAT_MASK[i] ? REPEAT : LONG;
                        end else if (holdCnt[i] != CNT_MAX) begin
                            holdCnt[i] <= holdCnt[i] + CNT_W'(1);
                        end
                    end
                    REPEAT: begin
                        if (!stable[i]) begin
                            state[i]   <= IDLE;
                            holdCnt[i] <= '0;
                        end else if (holdCnt[i] == RP_LAST) begin
                            holdCnt[i] <= '0;
                        end else if (holdCnt[i] != CNT_MAX) begin
                            holdCnt[i] <= holdCnt[i] + CNT_W'(1);
                        end
                    end
                    LONG: begin
                        if (!stable[i]) begin
                            state[i]   <= IDLE;
                            holdCnt[i] <= '0;
                        end
                    end
                    default: begin
                        state[i]   <= IDLE;
                        holdCnt[i] <= '0;
                    end
                endcase
            end
        end
    end

`ifdef BTN_CHORD_EN
    // Chord stays latched until both buttons have been debounced as released.
    always_ff @(posedge clk) begin
        if (reset) begin
            chordActive <= 1'b0;
            chordPulse  <= 1'b0;
        end else begin
            chordPulse <= chordHit;
            if (chordHit)                  chordActive <= 1'b1;
            else if (stable[1:0] == 2'b00) chordActive <= 1'b0;
        end
    end
`else
    assign chordPulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_input_frontend.sv
// Bench for button_input_frontend: directed scenarios plus random bounce, all checked every cycle
// against an event-time reference model (press time + L, + L + k*R, cut off by release).
module tb_button_input_frontend;

    localparam int D = 4;
    localparam int L = 20;
    localparam int R = 5;
    localparam logic [3:0] RMASK = 4'b0001;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] btnIn = '0;
    logic [3:0] btnState, pressPulse, releasePulse, longPress;
    logic       chordPulse;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         cyc = 0;
    int         hs [4];
    int         runLen [4];
    logic [3:0] h1, h2, mStable;
    logic [3:0] ePress, eRel, eLong;
    logic       eChord;
    bit         chordOn;

    button_input_frontend #(
        .NBTN(4), .DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L),
        .REPEAT_CYCLES(R), .REPEAT_MASK(RMASK), .CNT_W(16)
    ) dut (
        .clk(clk), .reset(reset), .btnIn(btnIn), .btnState(btnState),
        .pressPulse(pressPulse), .releasePulse(releasePulse),
        .longPress(longPress), .chordPulse(chordPulse)
    );

    always #5 clk = ~clk;

    // Model: a press strobe one clock after the debounced level rises; long at +L;
    // repeats every R after that on masked buttons; release one clock after the level falls.
    task automatic modelStep();
        logic [3:0] stOld, startNow;
        bit hit;
        int age;
        cyc++;
        if (reset) begin
            h1 = '0; h2 = '0; mStable = '0;
            ePress = '0; eRel = '0; eLong = '0; eChord = 1'b0; chordOn = 0;
            for (int i = 0; i < 4; i++) begin hs[i] = -1; runLen[i] = 0; end
        end else begin
            stOld = mStable;
            ePress = '0; eRel = '0; eLong = '0; eChord = 1'b0; hit = 0;
            for (int i = 0; i < 4; i++) startNow[i] = (hs[i] < 0) && stOld[i];
`ifdef BTN_CHORD_EN
            hit = !chordOn &&
                  ((startNow[0] && (startNow[1] || (hs[1] >= 0 && stOld[1] && cyc - hs[1] <= L))) ||
                   (startNow[1] && hs[0] >= 0 && stOld[0] && cyc - hs[0] <= L));
`endif
            for (int i = 0; i < 4; i++) begin
                if (startNow[i]) begin
                    ePress[i] = 1'b1;
                    hs[i] = cyc;
                end else if (hs[i] >= 0 && !stOld[i]) begin
                    eRel[i] = 1'b1;
                    hs[i] = -1;
                end else if (hs[i] >= 0) begin
                    age = cyc - hs[i];
                    if (age == L) eLong[i] = 1'b1;
                    else if (RMASK[i] && age > L && (age - L) % R == 0) ePress[i] = 1'b1;
                end
            end
`ifdef BTN_CHORD_EN
            if (hit) begin
                eChord = 1'b1;
                if (startNow[1]) ePress[1] = 1'b0;
                else             ePress[0] = 1'b0;
            end
            if (hit || chordOn) begin
                for (int b = 0; b < 2; b++) begin
                    if (!startNow[b]) ePress[b] = 1'b0;
                    eLong[b] = 1'b0;
                end
            end
            if (hit) chordOn = 1;
            else if (stOld[1:0] == 2'b00) chordOn = 0;
`endif
            // Debounce: accept a level after D consecutive differing synchronised samples.
            for (int i = 0; i < 4; i++) begin
                if (h2[i] != mStable[i]) begin
                    runLen[i]++;
                    if (runLen[i] == D) begin mStable[i] = h2[i]; runLen[i] = 0; end
                end else begin
                    runLen[i] = 0;
                end
            end
            h2 = h1;
            h1 = btnIn;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        btnIn = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({btnState, pressPulse, releasePulse, longPress, chordPulse} !== 17'd0) begin
                errors++;
                $display("FAIL reset_outputs got=%h exp=0", {btnState, pressPulse, releasePulse, longPress, chordPulse});
            end
        end
        reset = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            checks++;
            if ({btnState, pressPulse, releasePulse, longPress, chordPulse} !== {mStable, ePress, eRel, eLong, eChord}) begin
                errors++;
                $display("FAIL reset_model cyc=%0d got=%h exp=%h", cyc,
                         {btnState, pressPulse, releasePulse, longPress, chordPulse}, {mStable, ePress, eRel, eLong, eChord});
            end
            if (k == 5) begin
                checks++;
                if (btnState !== 4'b0000) begin errors++; $display("FAIL reset_state_early got=%b exp=0000", btnState); end
            end
            if (k == 6) begin
                checks++;
                if (btnState !== 4'b1111 || pressPulse !== 4'b0000) begin
                    errors++; $display("FAIL reset_state_6 got=%b/%b exp=1111/0000", btnState, pressPulse);
                end
            end
            if (k == 7) begin
                checks++;
`ifdef BTN_CHORD_EN
                if (pressPulse !== 4'b1101 || chordPulse !== 1'b1) begin
                    errors++; $display("FAIL reset_press_7 got=%b/%b exp=1101/1", pressPulse, chordPulse);
                end
`else
                if (pressPulse !== 4'b1111) begin
                    errors++; $display("FAIL reset_press_7 got=%b exp=1111", pressPulse);
                end
`endif
                btnIn = 4'b0000;
            end
        end
    endtask

    task automatic test_bounce();
        int pressCnt = 0;
        int pressAt = -1;
        for (int c = 0; c < 40; c++) begin
            btnIn[1] = ((c / 2) % 2 == 0);
            tick();
            checks++;
            if ({btnState, pressPulse, releasePulse, longPress, chordPulse} !== {mStable, ePress, eRel, eLong, eChord}) begin
                errors++;
                $display("FAIL bounce_model cyc=%0d got=%h exp=%h", cyc,
                         {btnState, pressPulse, releasePulse, longPress, chordPulse}, {mStable, ePress, eRel, eLong, eChord});
            end
            if (pressPulse[1] || releasePulse[1]) pressCnt += 100;
        end
        btnIn[1] = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            tick();
            checks++;
            if ({btnState, pressPulse, releasePulse, longPress, chordPulse} !== {mStable, ePress, eRel, eLong, eChord}) begin
                errors++;
                $display("FAIL bounce_model cyc=%0d got=%h exp=%h", cyc,
                         {btnState, pressPulse, releasePulse, longPress, chordPulse}, {mStable, ePress, eRel, eLong, eChord});
            end
            if (pressPulse[1]) begin pressCnt++; pressAt = k; end
            if (k == 12) btnIn[1] = 1'b0;
        end
        checks++;
        if (pressCnt !== 1 || pressAt !== 7) begin
            errors++; $display("FAIL bounce_press count=%0d at=%0d exp count=1 at=7", pressCnt, pressAt);
        end
    endtask

    task automatic test_repeat();
        int expQ[$];
        int longCnt = 0, longAt = -1, relAt = -1;
        expQ.push_back(D + 3);
        // The strobe due at 67 coincides with release and is dropped.
        for (int t = D + 3 + L + R; t < 60 + D + 3; t += R) expQ.push_back(t);
        btnIn[0] = 1'b1;
        for (int k = 1; k <= 78; k++) begin
            tick();
            checks++;
            if ({btnState, pressPulse, releasePulse, longPress, chordPulse} !== {mStable, ePress, eRel, eLong, eChord}) begin
                errors++;
                $display("FAIL repeat_model cyc=%0d got=%h exp=%h", cyc,
                         {btnState, pressPulse, releasePulse, longPress, chordPulse}, {mStable, ePress, eRel, eLong, eChord});
            end
            if (pressPulse[0]) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++; $display("FAIL repeat_extra_press at=%0d exp none", k);
                end else begin
                    if (k !== expQ[0]) begin errors++; $display("FAIL repeat_press_time got=%0d exp=%0d", k, expQ[0]); end
                    void'(expQ.pop_front());
                end
            end
            if (longPress[0]) begin longCnt++; longAt = k; end
            if (releasePulse[0]) relAt = k;
            if (k == 60) btnIn[0] = 1'b0;
        end
        checks++;
        if (expQ.size() != 0) begin errors++; $display("FAIL repeat_missing got=%0d left exp=0", expQ.size()); end
        checks++;
        if (longCnt !== 1 || longAt !== 27) begin errors++; $display("FAIL repeat_long count=%0d at=%0d exp 1 at 27", longCnt, longAt); end
        checks++;
        if (relAt !== 67) begin errors++; $display("FAIL repeat_release got=%0d exp=67", relAt); end
    endtask

    task automatic test_no_repeat();
        int pressCnt = 0, pressAt = -1, longCnt = 0, longAt = -1, relAt = -1;
        btnIn[2] = 1'b1;
        for (int k = 1; k <= 78; k++) begin
            tick();
            checks++;
            if ({btnState, pressPulse, releasePulse, longPress, chordPulse} !== {mStable, ePress, eRel, eLong, eChord}) begin
                errors++;
                $display("FAIL norepeat_model cyc=%0d got=%h exp=%h", cyc,
                         {btnState, pressPulse, releasePulse, longPress, chordPulse}, {mStable, ePress, eRel, eLong, eChord});
            end
            if (pressPulse[2]) begin pressCnt++; pressAt = k; end
            if (longPress[2]) begin longCnt++; longAt = k; end
            if (releasePulse[2]) relAt = k;
            if (k == 60) btnIn[2] = 1'b0;
        end
        checks++;
        if (pressCnt !== 1 || pressAt !== 7) begin errors++; $display("FAIL norepeat_press count=%0d at=%0d exp 1 at 7", pressCnt, pressAt); end
        checks++;
        if (longCnt !== 1 || longAt !== 27) begin errors++; $display("FAIL norepeat_long count=%0d at=%0d exp 1 at 27", longCnt, longAt); end
        checks++;
        if (relAt !== 67) begin errors++; $display("FAIL norepeat_release got=%0d exp=67", relAt); end
    endtask

    task automatic test_release_at_long();
        int longCnt = 0, relAt = -1, repressAt = -1;
        btnIn[3] = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            tick();
            checks++;
            if ({btnState, pressPulse, releasePulse, longPress, chordPulse} !== {mStable, ePress, eRel, eLong, eChord}) begin
                errors++;
                $display("FAIL rellong_model cyc=%0d got=%h exp=%h", cyc,
                         {btnState, pressPulse, releasePulse, longPress, chordPulse}, {mStable, ePress, eRel, eLong, eChord});
            end
            if (longPress[3]) longCnt++;
            if (releasePulse[3] && relAt < 0) relAt = k;
            if (pressPulse[3] && k > 30) repressAt = k;
            if (k == 20) btnIn[3] = 1'b0;
            if (k == 30) btnIn[3] = 1'b1;
            if (k == 40) btnIn[3] = 1'b0;
        end
        checks++;
        if (relAt !== 27 || longCnt !== 0) begin errors++; $display("FAIL rellong_release rel=%0d long=%0d exp rel=27 long=0", relAt, longCnt); end
        checks++;
        if (repressAt !== 37) begin errors++; $display("FAIL rellong_repress got=%0d exp=37", repressAt); end
    endtask

    task automatic test_reset_mid_press();
        int pressAt = -1;
        btnIn[0] = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            checks++;
            if ({btnState, pressPulse, releasePulse, longPress, chordPulse} !== {mStable, ePress, eRel, eLong, eChord}) begin
                errors++;
                $display("FAIL midreset_model cyc=%0d got=%h exp=%h", cyc,
                         {btnState, pressPulse, releasePulse, longPress, chordPulse}, {mStable, ePress, eRel, eLong, eChord});
            end
        end
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({btnState, pressPulse, releasePulse, longPress, chordPulse} !== 17'd0) begin
            errors++; $display("FAIL midreset_outputs got=%h exp=0", {btnState, pressPulse, releasePulse, longPress, chordPulse});
        end
        reset = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            checks++;
            if ({btnState, pressPulse, releasePulse, longPress, chordPulse} !== {mStable, ePress, eRel, eLong, eChord}) begin
                errors++;
                $display("FAIL midreset_model cyc=%0d got=%h exp=%h", cyc,
                         {btnState, pressPulse, releasePulse, longPress, chordPulse}, {mStable, ePress, eRel, eLong, eChord});
            end
            if (pressPulse[0] && pressAt < 0) pressAt = k;
            if (k == 8) btnIn[0] = 1'b0;
        end
        checks++;
        if (pressAt !== 7) begin errors++; $display("FAIL midreset_press got=%0d exp=7", pressAt); end
    endtask

`ifdef BTN_CHORD_EN
    task automatic test_chord();
        int p0 = 0, p1 = 0, chordAt = -1, longs = 0, rel0 = 0, rel1 = 0;
        btnIn[0] = 1'b1;
        for (int k = 1; k <= 75; k++) begin
            tick();
            checks++;
            if ({btnState, pressPulse, releasePulse, longPress, chordPulse} !== {mStable, ePress, eRel, eLong, eChord}) begin
                errors++;
                $display("FAIL chord_model cyc=%0d got=%h exp=%h", cyc,
                         {btnState, pressPulse, releasePulse, longPress, chordPulse}, {mStable, ePress, eRel, eLong, eChord});
            end
            p0 += pressPulse[0];
            p1 += pressPulse[1];
            longs += longPress[0] + longPress[1];
            rel0 += releasePulse[0];
            rel1 += releasePulse[1];
            if (chordPulse) chordAt = k;
            if (k == 8) btnIn[1] = 1'b1;
            if (k == 60) btnIn[1:0] = 2'b00;
        end
        checks++;
        if (p0 !== 1 || p1 !== 0 || chordAt !== 15) begin
            errors++; $display("FAIL chord_strobes p0=%0d p1=%0d chord=%0d exp 1/0/15", p0, p1, chordAt);
        end
        checks++;
        if (longs !== 0 || rel0 !== 1 || rel1 !== 1) begin
            errors++; $display("FAIL chord_hold long=%0d rel0=%0d rel1=%0d exp 0/1/1", longs, rel0, rel1);
        end
    endtask
`endif

    task automatic test_random();
        int remain [4];
        for (int i = 0; i < 4; i++) remain[i] = 1;
        for (int c = 0; c < 2500; c++) begin
            for (int i = 0; i < 4; i++) begin
                remain[i]--;
                if (remain[i] <= 0) begin
                    btnIn[i] = ~btnIn[i];
                    remain[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 90));
                end
            end
            reset = ($urandom_range(0, 399) == 0);
            tick();
            checks++;
            if ({btnState, pressPulse, releasePulse, longPress, chordPulse} !== {mStable, ePress, eRel, eLong, eChord}) begin
                errors++;
                $display("FAIL random_model cyc=%0d got=%h exp=%h", cyc,
                         {btnState, pressPulse, releasePulse, longPress, chordPulse}, {mStable, ePress, eRel, eLong, eChord});
            end
        end
        reset = 1'b0;
        btnIn = '0;
        for (int k = 0; k < 12; k++) begin
            tick();
            checks++;
            if ({btnState, pressPulse, releasePulse, longPress, chordPulse} !== {mStable, ePress, eRel, eLong, eChord}) begin
                errors++;
                $display("FAIL random_drain cyc=%0d got=%h exp=%h", cyc,
                         {btnState, pressPulse, releasePulse, longPress, chordPulse}, {mStable, ePress, eRel, eLong, eChord});
            end
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_repeat();
        test_no_repeat();
        test_release_at_long();
        test_reset_mid_press();
`ifdef BTN_CHORD_EN
        test_chord();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
